// File: rtl/edge_event_arbiter.sv
// Rising-edge capture on N synchronised level inputs, serialised round-robin over valid/ready.
// Optional EDGE_ARB_DROP_CNT_EN adds a saturating dropped-edge counter (drop_cnt, drop_cnt_clr).
//
// state   | meaning
// S_IDLE  | no event offered; arbitrate among pending channels
// S_OFFER | evt_chan offered, held until evt_ready
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  sig_in,
  input  logic [N-1:0]  chan_mask,
  output logic          evt_valid,
  output logic [CW-1:0] evt_chan,
  input  logic          evt_ready,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  drop_pulse
`ifdef EDGE_ARB_DROP_CNT_EN
  ,
  input  logic          drop_cnt_clr,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  prev;
  logic [N-1:0]  edge_det;
  logic [N-1:0]  clear;
  logic [N-1:0]  pending_nxt;
  logic [N-1:0]  drop_nxt;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] pick;
  logic          pick_found;
  logic          accept;

  assign edge_det = sig_in & ~prev & chan_mask;
  assign accept   = evt_valid & evt_ready;

  // A fresh edge wins over the clear of an accepted event, so nothing is lost.
  always_comb begin
    clear       = '0;
    pending_nxt = pending;
    drop_nxt    = '0;
    for (int i = 0; i < N; i++) begin
      clear[i] = accept && (evt_chan == CW'(i));
      if (edge_det[i]) begin
        pending_nxt[i] = 1'b1;
        drop_nxt[i]    = pending[i] & ~clear[i];
      end else if (clear[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Scan from farthest to nearest so the nearest pending channel after rr_ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (pending[idx]) begin
        pick       = CW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      pending    <= '0;
      drop_pulse <= '0;
      evt_valid  <= 1'b0;
      evt_chan   <= '0;
      rr_ptr     <= CW'(N - 1);
      state      <= S_IDLE;
    end else begin
      prev       <= sig_in;
      pending    <= pending_nxt;
      drop_pulse <= drop_nxt;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            evt_chan  <= pick;
            evt_valid <= 1'b1;
            state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            rr_ptr    <= evt_chan;
            state     <= S_IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef EDGE_ARB_DROP_CNT_EN
  int drop_sum;

  always_comb begin
    drop_sum = int'(drop_cnt);
    for (int i = 0; i < N; i++) begin
      drop_sum = drop_sum + (drop_pulse[i] ? 1 : 0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || drop_cnt_clr) begin
      drop_cnt <= 8'd0;
    end else if (drop_sum > 255) begin
      drop_cnt <= 8'd255;
    end else begin
      drop_cnt <= 8'(drop_sum);
    end
  end
`endif

endmodule
